// File: rtl/return_stack_reg_if.sv
// Register-port bundle for the return/data stack register: push/pop strobes in, top-of-stack and status out.
interface return_stack_reg_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 32
);
    logic [WIDTH-1:0]               data_in;
    logic                           load;
    logic                           read;
    logic [WIDTH-1:0]               data_out;
    logic [$clog2(DEPTH+1)-1:0]     count;
    logic                           empty;
    logic                           full;
    logic                           overflow;
    logic                           underflow;

    modport master (
        output data_in, load, read,
        input  data_out, count, empty, full, overflow, underflow
    );

    modport slave (
        input  data_in, load, read,
        output data_out, count, empty, full, overflow, underflow
    );
endinterface

// File: rtl/return_stack_reg.sv
// LIFO register behind one MCU register address; sticky overflow/underflow flags exist only with STACK_REG_GUARD_EN.
// Latency: push/pop take effect at the strobing posedge; data_out is a combinational read of the top entry.
// Backpressure: none; push while full overwrites the oldest entry, pop while empty is ignored.
module return_stack_reg #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 32
) (
    input  logic                sysclk,
    input  logic                sysreset_n,
    return_stack_reg_if.slave   stk
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    tp;
    logic [PW-1:0]    tp_inc;
    logic [PW-1:0]    tp_dec;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count_q;
    logic             is_empty;
    logic             is_full;
    logic             do_push;
    logic             do_pop;
    logic             do_replace;

    always_comb begin
        tp_inc     = (tp == PW'(DEPTH - 1)) ? '0 : tp + 1'b1;
        tp_dec     = (tp == '0) ? PW'(DEPTH - 1) : tp - 1'b1;
        is_empty   = (count_q == '0);
        is_full    = (count_q == CW'(DEPTH));
        // Simultaneous load+read on an empty stack degrades to a plain push.
        do_replace = stk.load && stk.read && !is_empty;
        do_push    = stk.load && !do_replace;
        do_pop     = stk.read && !stk.load && !is_empty;
        wr_ptr     = do_replace ? tp : tp_inc;
    end

    always_ff @(posedge sysclk or negedge sysreset_n) begin
        if (!sysreset_n) begin
            tp      <= '0;
            count_q <= '0;
        end else if (do_push) begin
            tp <= tp_inc;
            if (!is_full) begin
                count_q <= count_q + 1'b1;
            end
        end else if (do_pop) begin
            tp      <= tp_dec;
            count_q <= count_q - 1'b1;
        end
    end

    // Storage is never reset; stale words are masked by the empty check on data_out.
    always_ff @(posedge sysclk) begin
        if (stk.load) begin
            mem[wr_ptr] <= stk.data_in;
        end
    end

`ifdef STACK_REG_GUARD_EN
    logic ovf_q;
    logic unf_q;

    always_ff @(posedge sysclk or negedge sysreset_n) begin
        if (!sysreset_n) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (do_push && is_full) begin
                ovf_q <= 1'b1;
            end
            if (stk.read && !stk.load && is_empty) begin
                unf_q <= 1'b1;
            end
        end
    end

    assign stk.overflow  = ovf_q;
    assign stk.underflow = unf_q;
`else
    assign stk.overflow  = 1'b0;
    assign stk.underflow = 1'b0;
`endif

    assign stk.data_out = is_empty ? '0 : mem[tp];
    assign stk.count    = count_q;
    assign stk.empty    = is_empty;
    assign stk.full     = is_full;
endmodule

// File: tb/tb_return_stack_reg.sv
// Bench for return_stack_reg: vector table, directed corner sequences and random traffic against a queue model.
module tb_return_stack_reg;
    localparam int W = 16;
    localparam int D = 32;

`ifdef STACK_REG_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic sysclk     = 1'b0;
    logic sysreset_n = 1'b0;

    return_stack_reg_if #(.WIDTH(W), .DEPTH(D)) stk ();

    return_stack_reg #(.WIDTH(W), .DEPTH(D)) dut (
        .sysclk     (sysclk),
        .sysreset_n (sysreset_n),
        .stk        (stk)
    );

    always #5 sysclk = ~sysclk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] mq [$];
    bit           m_ovf;
    bit           m_unf;

    typedef struct {
        bit           ld;
        bit           rd;
        logic [W-1:0] din;
        logic [W-1:0] exp_dout;
        int           exp_cnt;
        bit           exp_empty;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] model_top();
        if (mq.size() == 0) return '0;
        return mq[mq.size()-1];
    endfunction

    task automatic check_model(input string tag);
        chk({tag, " data_out"},  32'(stk.data_out),  32'(model_top()));
        chk({tag, " count"},     32'(stk.count),     32'(mq.size()));
        chk({tag, " empty"},     32'(stk.empty),     32'(mq.size() == 0));
        chk({tag, " full"},      32'(stk.full),      32'(mq.size() == D));
        chk({tag, " overflow"},  32'(stk.overflow),  32'(m_ovf & GUARD));
        chk({tag, " underflow"}, 32'(stk.underflow), 32'(m_unf & GUARD));
    endtask

    task automatic model_clear();
        mq.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic model_op(input bit ld, input bit rd, input logic [W-1:0] din);
        if (ld && rd && mq.size() > 0) begin
            mq[mq.size()-1] = din;
        end else if (ld) begin
            if (mq.size() == D) begin
                void'(mq.pop_front());
                m_ovf = 1'b1;
            end
            mq.push_back(din);
        end else if (rd) begin
            if (mq.size() == 0) m_unf = 1'b1;
            else void'(mq.pop_back());
        end
    endtask

    // Inputs driven at negedge, edge applied, outputs checked at the following negedge.
    task automatic step(input bit ld, input bit rd, input logic [W-1:0] din, input string tag);
        stk.load    = ld;
        stk.read    = rd;
        stk.data_in = din;
        @(posedge sysclk);
        model_op(ld, rd, din);
        @(negedge sysclk);
        stk.load = 1'b0;
        stk.read = 1'b0;
        check_model(tag);
    endtask

    task automatic do_reset();
        @(negedge sysclk);
        sysreset_n = 1'b0;
        model_clear();
        @(negedge sysclk);
        sysreset_n = 1'b1;
        check_model("reset");
    endtask

    initial begin
        stk.load    = 1'b0;
        stk.read    = 1'b0;
        stk.data_in = '0;
        model_clear();

        tbl[0] = '{1'b1, 1'b0, 16'h1111, 16'h1111, 1, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 16'h2222, 16'h2222, 2, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 16'h3333, 16'h3333, 3, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 16'h0000, 16'h2222, 2, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 16'h0000, 16'h1111, 1, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 16'h0000, 16'h0000, 0, 1'b1};

        repeat (2) @(negedge sysclk);
        chk("reset count", 32'(stk.count), 32'd0);
        chk("reset empty", 32'(stk.empty), 32'd1);
        chk("reset data_out", 32'(stk.data_out), 32'd0);
        chk("reset overflow", 32'(stk.overflow), 32'd0);
        sysreset_n = 1'b1;
        @(negedge sysclk);

        // Basic LIFO ordering
        for (int i = 0; i < 6; i++) begin
            step(tbl[i].ld, tbl[i].rd, tbl[i].din, "vec");
            chk("vec data_out", 32'(stk.data_out), 32'(tbl[i].exp_dout));
            chk("vec count",    32'(stk.count),    32'(tbl[i].exp_cnt));
            chk("vec empty",    32'(stk.empty),    32'(tbl[i].exp_empty));
        end

        // Fill past DEPTH: oldest entry is overwritten
        for (int i = 0; i <= D; i++) begin
            step(1'b1, 1'b0, W'(i), "fill");
            if (i == D - 1) chk("full after 32 pushes", 32'(stk.full), 32'd1);
        end
        chk("count after 33 pushes", 32'(stk.count), 32'd32);
        chk("overflow after 33 pushes", 32'(stk.overflow), 32'(GUARD));
        for (int k = 0; k < D; k++) begin
            chk("drain top", 32'(stk.data_out), 32'(D - k));
            step(1'b0, 1'b1, '0, "drain");
        end
        chk("drained empty", 32'(stk.empty), 32'd1);

        // Pop while empty, then push
        step(1'b0, 1'b1, '0, "underflow");
        chk("underflow count", 32'(stk.count), 32'd0);
        chk("underflow data_out", 32'(stk.data_out), 32'd0);
        chk("underflow flag", 32'(stk.underflow), 32'(GUARD));
        step(1'b1, 1'b0, 16'hABCD, "push after underflow");
        chk("push after underflow data_out", 32'(stk.data_out), 32'hABCD);
        chk("push after underflow count", 32'(stk.count), 32'd1);

        // Simultaneous load+read
        do_reset();
        step(1'b1, 1'b0, 16'h0005, "push5");
        step(1'b1, 1'b1, 16'h0007, "replace");
        chk("replace data_out", 32'(stk.data_out), 32'h0007);
        chk("replace count", 32'(stk.count), 32'd1);
        step(1'b0, 1'b1, '0, "pop7");
        step(1'b1, 1'b1, 16'h0009, "both on empty");
        chk("both on empty count", 32'(stk.count), 32'd1);
        chk("both on empty data_out", 32'(stk.data_out), 32'h0009);
        chk("both on empty underflow", 32'(stk.underflow), 32'd0);

        // Asynchronous reset between edges with count=5 and overflow set
        do_reset();
        for (int i = 0; i < D + 5; i++) step(1'b1, 1'b0, W'(16'h100 + i), "ovf fill");
        for (int i = 0; i < D - 5; i++) step(1'b0, 1'b1, '0, "ovf pop");
        chk("pre-reset count", 32'(stk.count), 32'd5);
        chk("pre-reset overflow", 32'(stk.overflow), 32'(GUARD));
        #2 sysreset_n = 1'b0;
        #1;
        chk("async reset count", 32'(stk.count), 32'd0);
        chk("async reset overflow", 32'(stk.overflow), 32'd0);
        chk("async reset data_out", 32'(stk.data_out), 32'd0);
        chk("async reset empty", 32'(stk.empty), 32'd1);
        model_clear();
        stk.load    = 1'b1;
        stk.data_in = 16'hDEAD;
        @(negedge sysclk);
        chk("strobe in reset count", 32'(stk.count), 32'd0);
        stk.load   = 1'b0;
        sysreset_n = 1'b1;
        @(negedge sysclk);
        check_model("after async reset");

        // Random traffic in phases biased toward filling, draining and mixing
        begin
            int pct_ld [4] = '{80, 20, 50, 95};
            int pct_rd [4] = '{25, 85, 50, 40};
            for (int p = 0; p < 4; p++) begin
                for (int c = 0; c < 300; c++) begin
                    bit           ld;
                    bit           rd;
                    logic [W-1:0] din;
                    ld  = ($urandom_range(99) < 32'(pct_ld[p]));
                    rd  = ($urandom_range(99) < 32'(pct_rd[p]));
                    din = W'($urandom);
                    step(ld, rd, din, "rand");
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/return_stack_reg.md
# return_stack_reg

LIFO register for the MCU register file, used as the return/data stack behind a single register address. A write to the register pushes a word; a read of the register presents the top of stack and pops it. It is built as a circular buffer with a top pointer, an occupancy count and optional sticky overflow/underflow guard flags. It sits beside the general-purpose registers and is driven by the MCU's per-register load/read strobes.

## Interface
Parameters:
- WIDTH, 16, data word width in bits.
- DEPTH, 32, number of entries (≥2).

Ports:
- sysclk  in  1  system clock; all state changes on posedge.
- sysreset_n  in  1  reset, asynchronous, active-low.
- data_out  out  WIDTH  current top of stack; 0 when empty.
- data_in  in  WIDTH  word to push.
- load  in  1  push strobe (register write).
- read  in  1  pop strobe (register read).
- count  out  clog2(DEPTH+1)  number of valid entries, 0..DEPTH.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- overflow  out  1  sticky: a push was made while full (guard feature only).
- underflow  out  1  sticky: a pop was made while empty (guard feature only).

## Operation
- Storage is a DEPTH×WIDTH array with a top pointer tp (clog2(DEPTH) bits, wraps modulo DEPTH) and count.
- data_out = mem[tp] when count>0, else 0. It is a combinational read, so the consumer samples it in the same cycle it asserts read.
- Push only (load=1, read=0):
  - Not full: tp←tp+1 (wrapping), mem[new tp]←data_in, count+1.
  - Full: same pointer and write action, so the oldest entry is overwritten. count stays DEPTH and overflow is set.
- Pop only (read=1, load=0):
  - Not empty: tp←tp−1 (wrapping), count−1. Memory is unchanged.
  - Empty: no change to tp or count; underflow is set.
- Push and pop together (load=1, read=1):
  - Not empty: mem[tp]←data_in (replace top); tp and count unchanged; no flags set.
  - Empty: behaves as a plain push; no underflow.
- Neither strobe: hold.
- overflow and underflow are sticky and are cleared only by reset.
- Reset state: tp=0, count=0, empty=1, full=0, overflow=0, underflow=0, data_out=0. Memory contents are not reset and are never visible while empty.

## Timing
- Pushes and pops take effect at the posedge where the strobe is high. data_out, count, empty and full reflect the new state immediately after that edge (zero-cycle latency).
- Back-to-back strobes on consecutive cycles are supported, one operation per cycle.
- Asserting sysreset_n low mid-operation clears all state asynchronously, within the same cycle. Strobes are ignored while reset is asserted.
- Release of sysreset_n is synchronised externally by the system reset chain.
- empty and full are decoded directly from count with no added register stage.

## Configuration
- STACK_REG_GUARD_EN defined: overflow and underflow are implemented as described above.
- STACK_REG_GUARD_EN undefined: overflow and underflow are tied to 0 and their flops are not synthesised. All stack behaviour is otherwise identical, including wrap-on-full and ignore-pop-on-empty.

## Test plan
- Reset, then push 0x1111, 0x2222, 0x3333 → data_out=0x3333, count=3. Pop three times, sampling data_out before each pop → 0x3333, 0x2222, 0x1111; afterwards empty=1 and data_out=0.
- Push 33 values 0..32 with DEPTH=32 → after the 32nd push full=1; after the 33rd, count=32 and overflow=1 (guard build). 32 pops return 32, 31, …, 1.
- Pop while empty → count stays 0, data_out=0, underflow=1 (guard build) or 0 (non-guard build). A following push of 0xABCD gives data_out=0xABCD, count=1.
- Push 0x0005, then assert load and read together with data_in 0x0007 → data_out=0x0007 and count stays 1. Repeat with the stack empty → count=1, underflow=0.
- With count=5 and overflow=1, pull sysreset_n low between clock edges → count=0, overflow=0, data_out=0 at once, without waiting for a clock.
